// File: rtl/seq_mag_comp.sv
// Sequential MSB-first magnitude comparator: one DIGIT-bit slice per clock, stops at the first difference.
// Optional two's-complement mode via `define SEQ_MAG_COMP_SIGNED_EN.
module seq_mag_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2,
  localparam int NDIG = WIDTH / DIGIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       x,
  input  logic [WIDTH-1:0]       y,
  output logic                   busy,
  output logic                   done,
  output logic                   gt,
  output logic                   lt,
  output logic                   eq,
  output logic [$clog2(NDIG):0]  ndig
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NDIG - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, gt_d, lt_d, eq_d;
  logic [CNT_W-1:0] ndig_d;
  logic [WIDTH-1:0] xs, ys;
  logic [DIGIT-1:0] slice_a, slice_b;

  function automatic logic [DIGIT-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                input logic [IDX_W-1:0] i);
    return v[int'(i)*DIGIT +: DIGIT];
  endfunction

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    gt_d    = gt;
    lt_d    = lt;
    eq_d    = eq;
    ndig_d  = ndig;
    xs      = xr_q;
    ys      = yr_q;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    // Flipping the sign bits maps two's complement onto unsigned ordering.
    if (idx_q == TOP_IDX) begin
      xs[WIDTH-1] = ~xr_q[WIDTH-1];
      ys[WIDTH-1] = ~yr_q[WIDTH-1];
    end
`endif
    slice_a = slice_of(xs, idx_q);
    slice_b = slice_of(ys, idx_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          xr_d    = x;
          yr_d    = y;
          idx_d   = TOP_IDX;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (slice_a != slice_b || idx_q == '0) begin
          gt_d    = (slice_a > slice_b);
          lt_d    = (slice_a < slice_b);
          eq_d    = (slice_a == slice_b);
          ndig_d  = cnt_q + 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      ndig    <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      gt      <= gt_d;
      lt      <= lt_d;
      eq      <= eq_d;
      ndig    <= ndig_d;
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: WIDTH=8 with DIGIT=1/2/4/8 side by side, plus WIDTH=16/DIGIT=1.
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] st = '0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       st16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;

  wire [3:0] busy_v, done_v, gt_v, lt_v, eq_v;
  wire [3:0] nd_0;
  wire [2:0] nd_1;
  wire [1:0] nd_2;
  wire [0:0] nd_3;
  wire       busy16, done16, gt16, lt16, eq16;
  wire [4:0] nd16;

  int n_chk = 0, n_err = 0;
  int r_g[4], r_l[4], r_e[4], r_n[4], r_dc[4], r_bc[4];

  always #5 clk = ~clk;

  seq_mag_comp #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .start(st[0]), .x(x8), .y(y8),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .ndig(nd_0));
  seq_mag_comp #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .start(st[1]), .x(x8), .y(y8),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .ndig(nd_1));
  seq_mag_comp #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .start(st[2]), .x(x8), .y(y8),
    .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .ndig(nd_2));
  seq_mag_comp #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .start(st[3]), .x(x8), .y(y8),
    .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .lt(lt_v[3]), .eq(eq_v[3]), .ndig(nd_3));
  seq_mag_comp #(.WIDTH(16), .DIGIT(1)) u_w16 (.clk(clk), .rst_n(rst_n), .start(st16), .x(x16), .y(y16),
    .busy(busy16), .done(done16), .gt(gt16), .lt(lt16), .eq(eq16), .ndig(nd16));

  function automatic int nd_of(input int i);
    case (i)
      0: return int'(nd_0);
      1: return int'(nd_1);
      2: return int'(nd_2);
      default: return int'(nd_3);
    endcase
  endfunction

  // Reference: whole-operand integer compare; ndig from the highest differing slice.
  function automatic void ref_cmp(input logic [7:0] a, input logic [7:0] b, input int d,
                                  output int g, output int l, output int e, output int n);
    int nd, sa, sb, diff;
    nd = 8 / d;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    g = int'(sa > sb);
    l = int'(sa < sb);
    e = int'(sa == sb);
    diff = int'(a ^ b);
    n = nd;
    for (int s = 0; s < nd; s++)
      if (((diff >> (s * d)) & ((1 << d) - 1)) != 0) n = nd - s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge after E0; observes ncyc cycles and records each instance's result.
  task automatic watch(input int ncyc, input bit mess);
    for (int i = 0; i < 4; i++) begin
      r_dc[i] = 0; r_bc[i] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (busy_v[i]) r_bc[i]++;
        if (done_v[i]) begin
          r_dc[i]++;
          r_g[i] = int'(gt_v[i]); r_l[i] = int'(lt_v[i]);
          r_e[i] = int'(eq_v[i]); r_n[i] = nd_of(i);
        end
      end
      if (mess && c < 5) begin
        st = 4'b0001;
        x8 = 8'($urandom);
        y8 = 8'($urandom);
      end else begin
        st = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mask, input bit mess);
    int g, l, e, n;
    x8 = a; y8 = b; st = mask;
    @(negedge clk);
    st = '0;
    watch(12, mess);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        ref_cmp(a, b, 1 << i, g, l, e, n);
        chk($sformatf("done_count d%0d %h/%h", 1 << i, a, b), r_dc[i], 1);
        chk($sformatf("gt d%0d %h/%h", 1 << i, a, b), r_g[i], g);
        chk($sformatf("lt d%0d %h/%h", 1 << i, a, b), r_l[i], l);
        chk($sformatf("eq d%0d %h/%h", 1 << i, a, b), r_e[i], e);
        chk($sformatf("ndig d%0d %h/%h", 1 << i, a, b), r_n[i], n);
        chk($sformatf("busy_cycles d%0d %h/%h", 1 << i, a, b), r_bc[i], n);
      end
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int g, l, e, n;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int g, l, e, n, cyc;
    bit seen;

    // DIGIT=2 directed vectors with hand-derived results.
    tbl[0] = '{8'h40, 8'h3F, 1, 0, 0, 1};
    tbl[1] = '{8'hA5, 8'hA5, 0, 0, 1, 4};
    tbl[2] = '{8'hA4, 8'hA5, 0, 1, 0, 4};
`ifdef SEQ_MAG_COMP_SIGNED_EN
    tbl[3] = '{8'h80, 8'h7F, 0, 1, 0, 1};
`else
    tbl[3] = '{8'h80, 8'h7F, 1, 0, 0, 1};
`endif
    tbl[4] = '{8'h00, 8'h00, 0, 0, 1, 4};
    tbl[5] = '{8'hFF, 8'hFE, 1, 0, 0, 4};
    tbl[6] = '{8'h0C, 8'h08, 1, 0, 0, 3};

    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy_v), 0);
    chk("reset done", int'(done_v), 0);
    chk("reset gt", int'(gt_v), 0);
    chk("reset lt", int'(lt_v), 0);
    chk("reset eq", int'(eq_v), 0);
    chk("reset ndig d1", int'(nd_0), 0);
    chk("reset ndig w16", int'(nd16), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_cmp(tbl[i].x, tbl[i].y, 4'b1111, 1'b0);
      chk($sformatf("tbl%0d gt", i), r_g[1], tbl[i].g);
      chk($sformatf("tbl%0d lt", i), r_l[1], tbl[i].l);
      chk($sformatf("tbl%0d eq", i), r_e[1], tbl[i].e);
      chk($sformatf("tbl%0d ndig", i), r_n[1], tbl[i].n);
    end

    // 16-bit, 1-bit digits: MSB difference, sign-dependent outcome.
    x16 = 16'h8000; y16 = 16'h7FFF; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (done16) seen = 1'b1;
      else @(negedge clk);
    end
    chk("w16 done seen", int'(seen), 1);
`ifdef SEQ_MAG_COMP_SIGNED_EN
    chk("w16 gt", int'(gt16), 0);
    chk("w16 lt", int'(lt16), 1);
`else
    chk("w16 gt", int'(gt16), 1);
    chk("w16 lt", int'(lt16), 0);
`endif
    chk("w16 eq", int'(eq16), 0);
    chk("w16 ndig", int'(nd16), 1);
    @(negedge clk);

    // start and operand churn during an 8-slice scan.
    run_cmp(8'hA0, 8'hA1, 4'b0001, 1'b1);

    // start held on the done cycle launches the next compare.
    x8 = 8'hA5; y8 = 8'hA5; st = 4'b0010;
    @(negedge clk);
    st = '0;
    seen = 1'b0;
    for (cyc = 0; cyc < 12 && !seen; cyc++) begin
      if (done_v[1]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("b2b first done", int'(seen), 1);
    chk("b2b first eq", int'(eq_v[1]), 1);
    chk("b2b first ndig", int'(nd_1), 4);
    x8 = 8'h12; y8 = 8'h34; st = 4'b0010;
    @(negedge clk);
    st = '0;
    chk("b2b busy after done", int'(busy_v[1]), 1);
    chk("b2b done fell", int'(done_v[1]), 0);
    seen = 1'b0;
    for (cyc = 0; cyc < 12 && !seen; cyc++) begin
      if (done_v[1]) seen = 1'b1;
      else @(negedge clk);
    end
    ref_cmp(8'h12, 8'h34, 2, g, l, e, n);
    chk("b2b second done", int'(seen), 1);
    chk("b2b second gt", int'(gt_v[1]), g);
    chk("b2b second lt", int'(lt_v[1]), l);
    chk("b2b second ndig", int'(nd_1), n);
    @(negedge clk);

    // Asynchronous reset in the third scan cycle of an 8-slice compare.
    x8 = 8'hA0; y8 = 8'hA1; st = 4'b0001;
    @(negedge clk);
    st = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", int'(busy_v[0]), 0);
    chk("mid reset done", int'(done_v[0]), 0);
    chk("mid reset gt", int'(gt_v), 0);
    chk("mid reset lt", int'(lt_v), 0);
    chk("mid reset eq", int'(eq_v), 0);
    chk("mid reset ndig", int'(nd_0), 0);
    chk("mid reset w16 eq/lt", int'({lt16, gt16, eq16}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmp(8'd3, 8'd5, 4'b1111, 1'b0);

    for (int t = 0; t < 1000; t++)
      run_cmp(8'($urandom), 8'($urandom), 4'b1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
